// File: rtl/spi_flash_read_ctrl.sv
// Purpose: sequences one complete SPI flash READ (cmd, 24-bit addr, optional dummy, N data bytes) under a single CS.
// Latency: about one engine byte period per byte, plus two control cycles per byte and one cycle for done.
// Backpressure: rd_valid holds until rd_ready, and CS stays low; the next byte is not requested until the handshake.
module spi_flash_read_ctrl #(
  parameter int LEN_W          = 16,
  parameter bit FAST_READ      = 1'b0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             ctl_busy,
  output logic             done,
  output logic             err,
  output logic             spi_enabled,
  output logic [7:0]       spi_data_in,
  output logic             spi_continue_read,
  input  logic             spi_busy,
  input  logic [7:0]       spi_data_out
);

  // One extra bit so header + all-ones length still fits.
  localparam int IDX_W = LEN_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] HDR     = IDX_W'(FAST_READ ? 5 : 4);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       CMD     = FAST_READ ? 8'h0B : 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_OUT,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [IDX_W-1:0] last_idx, last_idx_d;
  logic [23:0]      addr_q, addr_d;
  logic [WD_W-1:0]  wdog, wdog_d;
  logic [7:0]       rd_data_d;
  logic             rd_valid_d;
  logic             ctl_busy_d;
  logic             done_d;
  logic             err_d;
  logic             spi_enabled_d;
  logic [7:0]       spi_data_in_d;
  logic             spi_continue_read_d;
  logic             wd_expired;
  logic             go_next;

  // Byte shifted out at position i: address bytes MSB first, everything else (dummy, data) is 0xFF.
  function automatic logic [7:0] byte_at(input logic [IDX_W-1:0] i, input logic [23:0] a);
    logic [7:0] b;
    b = 8'hFF;
    if (i == IDX_W'(1))      b = a[23:16];
    else if (i == IDX_W'(2)) b = a[15:8];
    else if (i == IDX_W'(3)) b = a[7:0];
    return b;
  endfunction

  // State and output registers; reset releases CS immediately.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      idx               <= '0;
      last_idx          <= '0;
      addr_q            <= '0;
      wdog              <= '0;
      rd_data           <= 8'h00;
      rd_valid          <= 1'b0;
      ctl_busy          <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      spi_enabled       <= 1'b0;
      spi_data_in       <= 8'hFF;
      spi_continue_read <= 1'b0;
    end else begin
      state             <= state_d;
      idx               <= idx_d;
      last_idx          <= last_idx_d;
      addr_q            <= addr_d;
      wdog              <= wdog_d;
      rd_data           <= rd_data_d;
      rd_valid          <= rd_valid_d;
      ctl_busy          <= ctl_busy_d;
      done              <= done_d;
      err               <= err_d;
      spi_enabled       <= spi_enabled_d;
      spi_data_in       <= spi_data_in_d;
      spi_continue_read <= spi_continue_read_d;
    end
  end

  // Next-state and next-output decode; registered outputs change on state transitions.
  always_comb begin
    state_d             = state;
    idx_d               = idx;
    last_idx_d          = last_idx;
    addr_d              = addr_q;
    rd_data_d           = rd_data;
    rd_valid_d          = rd_valid;
    ctl_busy_d          = ctl_busy;
    done_d              = 1'b0;
    err_d               = err;
    spi_enabled_d       = spi_enabled;
    spi_data_in_d       = spi_data_in;
    spi_continue_read_d = 1'b0;
    wdog_d              = wdog;
    go_next             = 1'b0;
    wd_expired          = (wdog == WD_LAST);

    case (state)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (len != '0) begin
            addr_d        = addr;
            last_idx_d    = HDR + IDX_W'(len) - IDX_W'(1);
            idx_d         = '0;
            ctl_busy_d    = 1'b1;
            spi_enabled_d = 1'b1;
            spi_data_in_d = CMD;
            state_d       = S_WAIT_HI;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_WAIT_HI: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (spi_busy) begin
          state_d = S_WAIT_LO;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_WAIT_LO: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (!spi_busy) begin
          if (idx < HDR) begin
            go_next = 1'b1;
          end else begin
            rd_data_d  = spi_data_out;
            rd_valid_d = 1'b1;
            state_d    = S_OUT;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_OUT: begin
        // A handshake coinciding with abort still completes; abort then ends the read.
        if (rd_ready || abort) begin
          rd_valid_d = 1'b0;
          if (abort || idx == last_idx) state_d = S_FINISH;
          else                          go_next = 1'b1;
        end
      end
      S_NEXT: begin
        state_d = abort ? S_FINISH : S_WAIT_HI;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Present the next byte together with the one-cycle continue pulse.
    if (go_next) begin
      state_d             = S_NEXT;
      idx_d               = idx + IDX_W'(1);
      spi_data_in_d       = byte_at(idx + IDX_W'(1), addr_q);
      spi_continue_read_d = 1'b1;
    end

    // Every way into FINISH releases CS, drops busy/valid and pulses done.
    if (state_d == S_FINISH && state != S_FINISH) begin
      spi_enabled_d = 1'b0;
      ctl_busy_d    = 1'b0;
      rd_valid_d    = 1'b0;
      done_d        = 1'b1;
    end

    // Watchdog restarts on every state entry and saturates at its limit.
    if (state_d != state)  wdog_d = '0;
    else if (!wd_expired)  wdog_d = wdog + WD_W'(1);
  end

endmodule
